// File: rtl/rv32_pkg.sv
// Shared RV32I constants and field layouts used by the issue stage and later pipeline stages.
package rv32_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // R/I-type field overlay; for OP-IMM the rs2 slot carries the shift amount.
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] major;
    } instr_fields_t;

endpackage

// File: rtl/rv32_alu_issue_if.sv
// Bundle of the instruction handshake, ALU output slot and writeback port of the issue stage.
interface rv32_alu_issue_if #(parameter int XLEN = 32);

    logic [31:0]     instr_in;
    logic            instr_valid_in;
    logic            instr_ready_out;
    logic [XLEN-1:0] op_1_out;
    logic [XLEN-1:0] op_2_out;
    logic [3:0]      opcode_out;
    logic [4:0]      rd_out;
    logic            valid_out;
    logic            ready_in;
    logic            wb_en_in;
    logic [4:0]      wb_rd_in;
    logic [XLEN-1:0] wb_data_in;
    logic            illegal_out;

    modport master (
        output instr_in, instr_valid_in, ready_in, wb_en_in, wb_rd_in, wb_data_in,
        input  instr_ready_out, op_1_out, op_2_out, opcode_out, rd_out, valid_out, illegal_out
    );

    modport slave (
        input  instr_in, instr_valid_in, ready_in, wb_en_in, wb_rd_in, wb_data_in,
        output instr_ready_out, op_1_out, op_2_out, opcode_out, rd_out, valid_out, illegal_out
    );

endinterface

// File: rtl/rv32_regfile.sv
// 32-entry register file: two read ports, one write port, x0 hardwired to zero, write-through bypass.
module rv32_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic [4:0]      rd_addr_a_in,
    output logic [XLEN-1:0] rd_data_a_out,
    input  logic [4:0]      rd_addr_b_in,
    output logic [XLEN-1:0] rd_data_b_out,
    input  logic            wr_en_in,
    input  logic [4:0]      wr_addr_in,
    input  logic [XLEN-1:0] wr_data_in
);

    logic [XLEN-1:0] regs [32];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en_in && wr_addr_in != 5'd0) begin
            regs[wr_addr_in] <= wr_data_in;
        end
    end

    // A read of the register being written this cycle sees the incoming data.
    always_comb begin
        rd_data_a_out = regs[rd_addr_a_in];
        if (rd_addr_a_in == 5'd0) begin
            rd_data_a_out = '0;
        end else if (wr_en_in && wr_addr_in == rd_addr_a_in) begin
            rd_data_a_out = wr_data_in;
        end

        rd_data_b_out = regs[rd_addr_b_in];
        if (rd_addr_b_in == 5'd0) begin
            rd_data_b_out = '0;
        end else if (wr_en_in && wr_addr_in == rd_addr_b_in) begin
            rd_data_b_out = wr_data_in;
        end
    end

endmodule

// File: rtl/rv32_alu_issue.sv
// Issue stage feeding rv32_alu: decodes OP/OP-IMM, reads operands, tracks busy registers, holds one output slot.
module rv32_alu_issue
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic           clk_in,
    input logic           rst_n_in,
    rv32_alu_issue_if.slave bus
);

    instr_fields_t   fields;
    logic            is_op;
    logic            is_op_imm;
    logic            legal;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] imm_op2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [31:0]     busy_q;
    logic [31:0]     busy_d;
    logic [31:0]     clear_mask;
    logic [31:0]     blocked;
    logic            hazard;
    logic            ready;
    logic            accept;
    logic            load;
    logic            valid_q;
    logic            illegal_q;
    logic [XLEN-1:0] op_1_q;
    logic [XLEN-1:0] op_2_q;
    logic [3:0]      opcode_q;
    logic [4:0]      rd_q;

    assign fields = bus.instr_in;

    rv32_regfile #(.XLEN(XLEN)) u_regfile (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .rd_addr_a_in  (fields.rs1),
        .rd_data_a_out (rs1_data),
        .rd_addr_b_in  (fields.rs2),
        .rd_data_b_out (rs2_data),
        .wr_en_in      (bus.wb_en_in),
        .wr_addr_in    (bus.wb_rd_in),
        .wr_data_in    (bus.wb_data_in)
    );

    // Decode: the alternate funct7 is only meaningful for SUB/SRA and SRAI.
    always_comb begin
        is_op     = 1'b0;
        is_op_imm = 1'b0;
        alu_op    = {1'b0, fields.funct3};
        imm_op2   = {{(XLEN-12){fields.funct7[6]}}, fields.funct7, fields.rs2};
        if (fields.major == OPC_OP) begin
            alu_op = {fields.funct7[5], fields.funct3};
            is_op  = (fields.funct7 == FUNCT7_BASE) ||
                     (fields.funct7 == FUNCT7_ALT &&
                      (fields.funct3 == 3'b000 || fields.funct3 == 3'b101));
        end else if (fields.major == OPC_OP_IMM) begin
            case (fields.funct3)
                3'b001: begin
                    alu_op    = {fields.funct7[5], fields.funct3};
                    imm_op2   = {{(XLEN-5){1'b0}}, fields.rs2};
                    is_op_imm = (fields.funct7 == FUNCT7_BASE);
                end
                3'b101: begin
                    alu_op    = {fields.funct7[5], fields.funct3};
                    imm_op2   = {{(XLEN-5){1'b0}}, fields.rs2};
                    is_op_imm = (fields.funct7 == FUNCT7_BASE) || (fields.funct7 == FUNCT7_ALT);
                end
                default: is_op_imm = 1'b1;
            endcase
        end
    end

    assign legal = is_op || is_op_imm;

    // A busy register retiring this cycle no longer blocks; illegal encodings never stall.
    always_comb begin
        clear_mask = '0;
        if (bus.wb_en_in) begin
            clear_mask[bus.wb_rd_in] = 1'b1;
        end
        blocked = busy_q & ~clear_mask;
        hazard  = legal && (blocked[fields.rs1] ||
                            (is_op && blocked[fields.rs2]) ||
                            (fields.rd != 5'd0 && blocked[fields.rd]));
    end

    assign ready  = (!valid_q || bus.ready_in) && !hazard;
    assign accept = bus.instr_valid_in && ready;
    assign load   = accept && legal;

    // Set applied after clear so a same-cycle issue to a retiring register keeps it busy.
    always_comb begin
        busy_d = busy_q & ~clear_mask;
        if (load && fields.rd != 5'd0) begin
            busy_d[fields.rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q    <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            op_1_q    <= '0;
            op_2_q    <= '0;
            opcode_q  <= '0;
            rd_q      <= '0;
        end else begin
            busy_q    <= busy_d;
            illegal_q <= accept && !legal;
            if (load) begin
                valid_q  <= 1'b1;
                op_1_q   <= rs1_data;
                op_2_q   <= is_op ? rs2_data : imm_op2;
                opcode_q <= alu_op;
                rd_q     <= fields.rd;
            end else if (bus.ready_in) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.instr_ready_out = ready;
    assign bus.valid_out       = valid_q;
    assign bus.illegal_out     = illegal_q;
    assign bus.op_1_out        = op_1_q;
    assign bus.op_2_out        = op_2_q;
    assign bus.opcode_out      = opcode_q;
    assign bus.rd_out          = rd_q;

endmodule
